// File: rtl/sipo.sv
// Serial-in, parallel-out UART receiver: 11-bit frame (start, 8 data LSB first,
// parity, stop) recovered by mid-bit sampling on an oversampling clock.
module sipo #(
  parameter int OVERSAMPLE = 16,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic       baud_clk,
  input  logic       reset,
  input  logic       data_rx,
  output logic [7:0] data_out,
  output logic       parity_bit_out,
  output logic       parity_err,
  output logic       frame_err,
  output logic       active_flag,
  output logic       done_flag
);

  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST    = TW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, BITS, STOP} state_t;

  state_t        state, state_next;
  logic          sync1, sync2, prev;
  logic [TW-1:0] tick, tick_next;
  logic [3:0]    bit_idx, bit_idx_next;
  logic [7:0]    shreg, shreg_next;
  logic          par_s, par_next;
  logic [7:0]    data_next;
  logic          pbit_next, perr_next, ferr_next, done_next;

  // Synchronizer and edge history reset low, so a start needs the line seen high first.
  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= data_rx;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      tick           <= '0;
      bit_idx        <= '0;
      shreg          <= '0;
      par_s          <= 1'b0;
      data_out       <= '0;
      parity_bit_out <= 1'b0;
      parity_err     <= 1'b0;
      frame_err      <= 1'b0;
      done_flag      <= 1'b0;
    end else begin
      state          <= state_next;
      tick           <= tick_next;
      bit_idx        <= bit_idx_next;
      shreg          <= shreg_next;
      par_s          <= par_next;
      data_out       <= data_next;
      parity_bit_out <= pbit_next;
      parity_err     <= perr_next;
      frame_err      <= ferr_next;
      done_flag      <= done_next;
    end
  end

  always_comb begin
    state_next   = state;
    tick_next    = tick;
    bit_idx_next = bit_idx;
    shreg_next   = shreg;
    par_next     = par_s;
    data_next    = data_out;
    pbit_next    = parity_bit_out;
    perr_next    = parity_err;
    ferr_next    = frame_err;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        tick_next    = '0;
        bit_idx_next = '0;
        if (prev && !sync2) state_next = START;
      end
      START: begin
        if (tick == HALF_M1) begin
          tick_next  = '0;
          state_next = sync2 ? IDLE : BITS;
        end else begin
          tick_next = tick + 1'b1;
        end
      end
      BITS: begin
        if (tick == LAST) begin
          tick_next = '0;
          if (bit_idx == 4'd8) begin
            par_next   = sync2;
            state_next = STOP;
          end else begin
            shreg_next   = {sync2, shreg[7:1]};
            bit_idx_next = bit_idx + 4'd1;
          end
        end else begin
          tick_next = tick + 1'b1;
        end
      end
      STOP: begin
        if (tick == LAST) begin
          tick_next  = '0;
          data_next  = shreg;
          pbit_next  = par_s;
          perr_next  = ((^shreg) ^ par_s) != ODD_PARITY;
          ferr_next  = !sync2;
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          tick_next = tick + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign active_flag = (state != IDLE);

endmodule

// File: tb/tb_sipo.sv
// Directed bench for sipo: even- and odd-check receivers share one serial line;
// expected frames are queued when driven and compared when done_flag pulses.
module tb_sipo;

  logic       baud_clk = 1'b0;
  logic       reset;
  logic       data_rx;
  logic [7:0] d_e, d_o;
  logic       pb_e, pe_e, fe_e, act_e, done_e;
  logic       pb_o, pe_o, fe_o, act_o, done_o;

  always #5 baud_clk = ~baud_clk;

  sipo #(.OVERSAMPLE(16), .ODD_PARITY(1'b0)) dut_even (
    .baud_clk(baud_clk), .reset(reset), .data_rx(data_rx),
    .data_out(d_e), .parity_bit_out(pb_e), .parity_err(pe_e),
    .frame_err(fe_e), .active_flag(act_e), .done_flag(done_e)
  );

  sipo #(.OVERSAMPLE(16), .ODD_PARITY(1'b1)) dut_odd (
    .baud_clk(baud_clk), .reset(reset), .data_rx(data_rx),
    .data_out(d_o), .parity_bit_out(pb_o), .parity_err(pe_o),
    .frame_err(fe_o), .active_flag(act_o), .done_flag(done_o)
  );

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       perr_e;
    logic       perr_o;
    logic       ferr;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0, cyc = 0, done_total = 0;
  int   run = 0, last_run = 0, rise_cyc = 0, done_cyc = 0, prev_done_cyc = 0;
  int   base;
  logic prev_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample outputs on the falling edge, then drive the next line value.
  task automatic tick(input logic rx);
    exp_t e;
    @(negedge baud_clk);
    cyc++;
    if (act_e === 1'b1) begin
      if (run == 0) rise_cyc = cyc;
      run++;
    end else if (run > 0) begin
      last_run = run;
      run = 0;
    end
    if (done_e === 1'b1) begin
      done_total++;
      prev_done_cyc = done_cyc;
      done_cyc = cyc;
      chk("done_width", {31'd0, prev_done}, 0);
      chk("done_odd", {31'd0, done_o}, 1);
      chk("sb_nonempty", {31'd0, sb.size() != 0}, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("data_out", {24'd0, d_e}, {24'd0, e.data});
        chk("data_out_odd", {24'd0, d_o}, {24'd0, e.data});
        chk("parity_bit_out", {31'd0, pb_e}, {31'd0, e.par});
        chk("parity_err_even", {31'd0, pe_e}, {31'd0, e.perr_e});
        chk("parity_err_odd", {31'd0, pe_o}, {31'd0, e.perr_o});
        chk("frame_err", {31'd0, fe_e}, {31'd0, e.ferr});
      end
    end
    prev_done = done_e;
    data_rx = rx;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) tick(1'b1);
  endtask

  task automatic send_bits(input logic [10:0] fr, input int unsigned nbits);
    for (int unsigned b = 0; b < nbits; b++) repeat (16) tick(fr[b]);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    exp_t e;
    e.data   = d;
    e.par    = p;
    e.perr_e = ^{d, p};
    e.perr_o = ~^{d, p};
    e.ferr   = ~s;
    sb.push_back(e);
    send_bits({s, p, d, 1'b0}, 11);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, {24'd0, d_e}, 0);
    chk({tag, "_pbit"}, {31'd0, pb_e}, 0);
    chk({tag, "_perr"}, {31'd0, pe_e}, 0);
    chk({tag, "_ferr"}, {31'd0, fe_e}, 0);
    chk({tag, "_active"}, {31'd0, act_e}, 0);
    chk({tag, "_done"}, {31'd0, done_e}, 0);
  endtask

  initial begin
    reset   = 1'b1;
    data_rx = 1'b1;
    repeat (3) tick(1'b1);
    chk_all_zero("reset");
    reset = 1'b0;
    idle(32);

    // Nominal frame: latency and active window
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(16);
    chk("a5_active_len", last_run, 168);
    chk("a5_done_latency", done_cyc - rise_cyc, 168);
    chk("a5_done_count", done_total, 1);

    // Parity checks, even and odd receivers
    send_frame(8'h01, 1'b0, 1'b1);
    idle(16);
    send_frame(8'h01, 1'b1, 1'b1);
    idle(16);

    // Framing error followed by a held-low break
    base = done_total;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (800) tick(1'b0);
    chk("break_done_count", done_total, base + 1);
    chk("break_ferr_held", {31'd0, fe_e}, 1);
    chk("break_data_held", {24'd0, d_e}, 8'h3C);
    idle(32);
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(16);
    chk("after_break_count", done_total, base + 2);

    // Glitch: false start
    base = done_total;
    repeat (4) tick(1'b0);
    idle(32);
    chk("glitch_active_len", last_run, 8);
    chk("glitch_no_done", done_total, base);
    chk("glitch_data", {24'd0, d_e}, 8'h5A);
    chk("glitch_ferr", {31'd0, fe_e}, 0);

    // Reset during data bit 3
    base = done_total;
    send_bits({1'b1, 1'b0, 8'h3C, 1'b0}, 4);
    repeat (8) tick(1'b1);
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    tick(1'b1);
    tick(1'b1);
    reset = 1'b0;
    idle(32);
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(16);
    chk("midreset_done_count", done_total, base + 1);

    // Back-to-back frames, no idle gap
    base = done_total;
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle(32);
    chk("b2b_done_count", done_total, base + 2);
    chk("b2b_spacing", done_cyc - prev_done_cyc, 176);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo.md
# sipo

Serial-in, parallel-out UART receiver. It is the receive-side counterpart of the UART transmitter and accepts the same 11-bit frame: start (0), 8 data bits LSB first, 1 externally generated parity bit, stop (1). It runs on one oversampling clock, recovers each frame by mid-bit sampling, and presents the byte, the received parity bit and the error status to the host with a one-cycle completion pulse.

## Interface
- OVERSAMPLE, 16: `baud_clk` cycles per bit period. Must be even and ≥ 4.
- ODD_PARITY, 0: 0 = even-parity check, 1 = odd-parity check.

- baud_clk  in  1  clock at OVERSAMPLE × bit rate
- reset  in  1  asynchronous, active-high reset
- data_rx  in  1  serial line, idle high, asynchronous to `baud_clk`
- data_out  out  8  last received byte
- parity_bit_out  out  1  parity bit of the last frame, as received
- parity_err  out  1  parity mismatch in the last frame
- frame_err  out  1  stop bit of the last frame sampled as 0
- active_flag  out  1  high while a frame is being received
- done_flag  out  1  one-cycle pulse when a frame completes

## Operation
- Input path: two-flop synchronizer on `data_rx`, then a previous-sample register for edge detection. All three registers reset to 0, so no start can be detected until the line has been seen high after reset.
- States: IDLE, START, BITS, STOP.
- IDLE:
  - Tick counter = 0, bit index = 0.
  - On a synchronized falling edge (previous = 1, current = 0), go to START.
- START:
  - Tick counts up to OVERSAMPLE/2−1, then the line is sampled.
  - Sample = 1: false start. Return to IDLE with no output change and no `done_flag`.
  - Sample = 0: tick = 0, go to BITS.
- BITS:
  - Tick counts 0..OVERSAMPLE−1. At OVERSAMPLE−1 the line is sampled and tick wraps to 0.
  - Bit index 0..7: sample is shifted into the data shift register, LSB first.
  - Bit index 8: sample is stored as the parity bit, then go to STOP.
- STOP: at tick OVERSAMPLE−1, sample the stop bit and, on the same edge:
  - data_out ← shift register; parity_bit_out ← parity sample.
  - parity_err ← (^data ^ parity) != ODD_PARITY.
  - frame_err ← (stop == 0).
  - done_flag ← 1; go to IDLE.
- Error handling:
  - A frame with an error is still delivered: `data_out` updates and `done_flag` pulses.
  - Error flags are held with the data until the next completed frame.
- After a framing error, IDLE requires a fresh falling edge, so a held-low (break) line produces no further frames until it returns high.
- active_flag = 1 in START, BITS and STOP; otherwise 0.
- Counter widths: tick counter is clog2(OVERSAMPLE) bits; bit index is 4 bits.

## Timing
- Reset values: data_out = 8'h00; parity_bit_out, parity_err, frame_err, active_flag, done_flag = 0; state = IDLE.
- Synchronizer latency: 2 `baud_clk` cycles from pin to edge detection.
- Let E be the edge on which IDLE→START occurs. Relative to E:
  - Start sample: E + OVERSAMPLE/2.
  - Bit k (k = 0..9, where 8 = parity and 9 = stop) sample: E + OVERSAMPLE/2 + (k+1)·OVERSAMPLE.
  - done_flag and outputs update at E + OVERSAMPLE/2 + 10·OVERSAMPLE. With the default OVERSAMPLE = 16, that is E + 168.
- `done_flag` is high for exactly one cycle. `active_flag` falls on the same edge that `done_flag` rises.
- Back-to-back frames: the FSM is in IDLE half a bit before the stop bit ends, so a start bit immediately following the stop bit is detected with no idle gap required.
- Reset mid-frame: the FSM and all outputs return to reset values immediately and the partial frame is discarded. Reception resumes only after the line is observed high and then falls.

## Test plan
- Frame 0xA5, parity 0, stop 1, OVERSAMPLE = 16, ODD_PARITY = 0 -> data_out = 8'hA5, parity_err = 0, frame_err = 0, done_flag a single pulse 168 clocks after start detection; active_flag high for exactly 168 cycles.
- Frame 0x01 with parity bit 0 (even check) -> data_out = 8'h01, parity_bit_out = 0, parity_err = 1, frame_err = 0; repeat with ODD_PARITY = 1 -> parity_err = 0.
- Frame 0x3C with stop bit 0, line then held low for 50 bit times -> one done_flag with frame_err = 1 and data_out = 8'h3C. No further done_flag until the line goes high then low, after which the next frame is received normally.
- Glitch: data_rx low for 4 clocks, then high -> active_flag rises and falls at the start sample (8 clocks after detection); no done_flag; outputs unchanged.
- Reset asserted during data bit 3 of a frame -> all outputs 0 within the reset cycle. After release, with the line high for 2 bit times, frame 0x3C with parity 0 -> data_out = 8'h3C, no errors.
- Back-to-back frames 0x00 then 0xFF (both parity 0) with no idle gap -> two done_flag pulses exactly 176 clocks apart (11 bit periods); data_out = 8'h00 then 8'hFF; no errors on either frame.
